bcd_seq_adder: RTL and testbench

Sequencer that adds two N-digit packed-BCD operands using a single one-digit BCD add slice, processing one digit per clock from least to most significant and carrying between digits through a register. It replaces the wide ripple chain of digit adders with one time-shared slice and a start/done handshake. The lab datapath uses it wherever multi-digit decimal sums are needed and area matters more than latency.

---
 rtl/bcd_seq_adder.sv | 79 +++++++
 tb/tb_bcd_seq_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: multi-digit packed-BCD adder built from one time-shared digit slice
module bcd_seq_adder #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                err
);
   localparam int W = 4*DIGITS;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [W-1:0] ra, rb;
   logic c, co;
   logic [IW-1:0] idx;
   logic [4:0] s;
   logic [3:0] d;
   // operands shift right so the slice always sees the current digit in [3:0]
   always_comb begin
      s = 5'(ra[3:0]) + 5'(rb[3:0]) + 5'(c);
      co = s > 5'd9;
      d = co ? 4'(s + 5'd6) : s[3:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ra <= '0;
         rb <= '0;
         c <= 1'b0;
         idx <= '0;
         sum <= '0;
         cout <= 1'b0;
         err <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               ra <= a;
               rb <= b;
               c <= cin;
               idx <= '0;
               sum <= '0;
               cout <= 1'b0;
               err <= 1'b0;
               busy <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               sum[4*idx +: 4] <= d;
               c <= co;
               ra <= ra >> 4;
               rb <= rb >> 4;
               idx <= idx + 1'b1;
               if (ra[3:0] > 4'd9 || rb[3:0] > 4'd9) err <= 1'b1;
               if (idx == IW'(DIGITS-1)) begin
                  cout <= co;
                  busy <= 1'b0;
                  done <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb_bcd_seq_adder: scoreboard bench for the sequential BCD adder
module tb_bcd_seq_adder;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic busy, done, cout, err;
   logic [15:0] sum;
   typedef struct packed {logic [15:0] s; logic co; logic e;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;

   bcd_seq_adder #(.DIGITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
      exp_t r;
      logic c;
      logic [4:0] t;
      r = '0;
      c = ci;
      for (int i = 0; i < 4; i++) begin
         t = 5'(x[4*i +: 4]) + 5'(y[4*i +: 4]) + 5'(c);
         if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) r.e = 1'b1;
         if (t > 5'd9) begin
            t = t + 5'd6;
            c = 1'b1;
         end else c = 1'b0;
         r.s[4*i +: 4] = t[3:0];
      end
      r.co = c;
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done sum=%h cout=%b err=%b", sum, cout, err);
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({sum, cout, err} !== {e.s, e.co, e.e}) begin
               errors++;
               $display("FAIL result sum=%h cout=%b err=%b expected sum=%h cout=%b err=%b",
                        sum, cout, err, e.s, e.co, e.e);
            end
         end
      end
   end

   task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic ci, input exp_t e, input bit push);
      @(negedge clk);
      a = x;
      b = y;
      cin = ci;
      start = 1'b1;
      if (push) q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (done) seen = 1;
         else @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout got no done expected done within 20 cycles");
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic [15:0] s, input logic co, input logic e);
      launch(x, y, ci, '{s: s, co: co, e: e}, 1);
      wait_done();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, sum, cout, err} !== 20'h0) begin
         errors++;
         $display("FAIL reset busy=%b done=%b sum=%h cout=%b err=%b expected all 0", busy, done, sum, cout, err);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      launch(16'h0058, 16'h0053, 1'b0, '{s: 16'h0111, co: 1'b0, e: 1'b0}, 1);
      for (int k = 1; k <= 5; k++) begin
         checks++;
         if (busy !== (k <= 4) || done !== (k == 5)) begin
            errors++;
            $display("FAIL timing cycle=%0d busy=%b done=%b expected busy=%b done=%b", k, busy, done, k <= 4, k == 5);
         end
         if (k < 5) @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_carry_in();
      run(16'h0004, 16'h0007, 1'b1, 16'h0012, 1'b0, 1'b0);
      run(16'h0009, 16'h0011, 1'b1, 16'h0021, 1'b0, 1'b0);
   endtask

   task automatic test_overflow();
      run(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
      run(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      a = 16'h0027;
      b = 16'h0021;
      cin = 1'b0;
      start = 1'b1;
      repeat (3) q.push_back('{s: 16'h0048, co: 1'b0, e: 1'b0});
      for (int op = 0; op < 3; op++) begin
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
               a = 16'h9999;
               b = 16'h9999;
            end
            if (k == 5) begin
               a = 16'h0027;
               b = 16'h0021;
            end
            if (k == 6 && op == 2) start = 1'b0;
            checks++;
            if (done !== (k == 5)) begin
               errors++;
               $display("FAIL b2b_done op=%0d cycle=%0d done=%b expected %b", op, k, done, k == 5);
            end
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      launch(16'h5858, 16'h5353, 1'b0, '0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, sum, cout, err} !== 20'h0) begin
         errors++;
         $display("FAIL mid_reset busy=%b done=%b sum=%h cout=%b err=%b expected all 0", busy, done, sum, cout, err);
      end
      repeat (8) @(negedge clk);
      run(16'h5858, 16'h5353, 1'b0, 16'h1211, 1'b1, 1'b0);
   endtask

   task automatic test_invalid();
      run(16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
      run(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         logic [15:0] x, y;
         logic ci;
         for (int i = 0; i < 4; i++) begin
            x[4*i +: 4] = 4'($urandom_range(9));
            y[4*i +: 4] = 4'($urandom_range(9));
         end
         ci = 1'($urandom_range(1));
         launch(x, y, ci, model(x, y, ci), 1);
         wait_done();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_in();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_invalid();
      test_random();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_results left=%0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
